rom_burst_ctrl: RTL and testbench

Burst-read sequencer between the 128×32 block ROM and the receive FIFO. It accepts a start command with a base address and a length, then streams ROM words into the FIFO at up to one word per cycle. It accounts for the ROM's one-cycle read latency and never drops a word when the FIFO fills. It replaces free-running fill logic so the Toeplitz datapath can request specific seed/matrix segments on demand.

---
 rtl/rom_burst_ctrl_pkg.sv | 27 ++
 rtl/rom_burst_ctrl_if.sv | 36 +++
 rtl/rom_burst_ctrl_skid_reg.sv | 43 ++++
 rtl/rom_burst_ctrl.sv | 100 ++++++++++
 tb/tb_rom_burst_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_burst_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rom_burst_ctrl_pkg
// Shared widths, limits, FSM state encoding and the burst-length clamp used by
// the ROM burst sequencer, its bus interface and its skid register.
// No ports (package).
// ---------------------------------------------------------------------------
package rom_burst_ctrl_pkg;

    localparam int ADDR_W    = 7;     // ROM address width
    localparam int DATA_W    = 32;    // ROM / FIFO word width
    localparam int LEN_W     = 8;     // burst length width (holds 0..128)
    localparam int ROM_DEPTH = 128;   // 2**ADDR_W words
    localparam int MAX_BURST = 128;   // longest burst; larger requests clamp

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requested lengths beyond one full pass of the ROM clamp to MAX_BURST.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len;
    endfunction

endpackage

// File: rtl/rom_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_burst_ctrl_if
// Groups the command, ROM and FIFO signals of the burst sequencer.
//   command : start, base_addr, burst_len, abort  -> sequencer
//   status  : busy, done                           <- sequencer
//   ROM     : rom_en, rom_addr (out), rom_data (in, one cycle after rom_en)
//   FIFO    : fifo_wr_en, fifo_din (out), fifo_full (in)
// Modports: master = the sequencer, slave = the surrounding system.
// ---------------------------------------------------------------------------
interface rom_burst_ctrl_if;
    import rom_burst_ctrl_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_full;

    modport master (
        input  start, base_addr, burst_len, abort, rom_data, fifo_full,
        output busy, done, rom_en, rom_addr, fifo_wr_en, fifo_din
    );

    modport slave (
        output start, base_addr, burst_len, abort, rom_data, fifo_full,
        input  busy, done, rom_en, rom_addr, fifo_wr_en, fifo_din
    );

endinterface

// File: rtl/rom_burst_ctrl_skid_reg.sv
// ---------------------------------------------------------------------------
// rom_skid_reg
// One-entry holding register that parks a ROM word arriving while the FIFO is
// full. Flush (and reset) win over load, load wins over unload.
// Ports:
//   clk_in  clock           rst_n   synchronous active-low reset
//   load    capture din     unload  release the held word
//   flush   discard content din/dout held word   valid  entry occupied
// ---------------------------------------------------------------------------
module rom_skid_reg
    import rom_burst_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= din;
            valid_reg <= 1'b1;
        end else if (unload) begin
            valid_reg <= 1'b0;
        end
    end

    assign dout  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/rom_burst_ctrl.sv
// ---------------------------------------------------------------------------
// rom_burst_ctrl
// Streams a burst of ROM words into the receive FIFO at up to one word per
// cycle, covering the ROM's one-cycle read latency and parking a word in a
// skid register when the FIFO fills so nothing is lost.
// Ports:
//   clk_in  clock (rising edge)
//   rst_n   synchronous active-low reset
//   bus     rom_burst_ctrl_if.master (command, status, ROM and FIFO signals)
// ---------------------------------------------------------------------------
module rom_burst_ctrl
    import rom_burst_ctrl_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n,
    rom_burst_ctrl_if.master bus
);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  remaining_reg;
    logic              rd_valid_reg;   // rom_data carries a word this cycle

    logic              issue;
    logic              abort_hit;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [LEN_W-1:0]  start_len;

    // Only one read may be outstanding: issue stops while the skid holds a
    // word, so rd_valid and skid_valid are never high together.
    assign issue     = (state_reg == ST_RUN) && (remaining_reg != '0) &&
                       !bus.fifo_full && !skid_valid;
    assign abort_hit = bus.abort && (state_reg != ST_IDLE);
    assign start_len = sat_len(bus.burst_len);

    rom_skid_reg u_skid (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .load   (rd_valid_reg && bus.fifo_full),
        .unload (skid_valid && !bus.fifo_full),
        .flush  (abort_hit),
        .din    (bus.rom_data),
        .dout   (skid_data),
        .valid  (skid_valid)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            rd_valid_reg  <= 1'b0;
        end else if (abort_hit) begin
            // Any word still in flight is dropped along with the burst.
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            rd_valid_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= issue;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_reg      <= bus.base_addr;
                        remaining_reg <= start_len;
                        state_reg     <= (start_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_reg      <= addr_reg + ADDR_W'(1);  // wraps 127 -> 0
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1))
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_valid_reg && !skid_valid)
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_en     = issue;
    assign bus.rom_addr   = addr_reg;
    assign bus.fifo_wr_en = (skid_valid || rd_valid_reg) && !bus.fifo_full;
    // The skid word is always older than anything on rom_data.
    assign bus.fifo_din   = skid_valid   ? skid_data    :
                            rd_valid_reg ? bus.rom_data : '0;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_rom_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_burst_ctrl
// Directed bench for rom_burst_ctrl with a behavioural ROM. Cycle 0 of each
// run is the cycle in which start is driven; all expected cycle numbers and
// counts below are worked out by hand from that origin.
// ---------------------------------------------------------------------------
module tb_rom_burst_ctrl;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    always #5 clk_in = ~clk_in;

    rom_burst_ctrl_if bus ();

    rom_burst_ctrl dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ROM contents: distinct, address-tagged words.
    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return {16'hC0DE, 1'b0, a, ~{1'b0, a}};
    endfunction

    always @(posedge clk_in) begin
        if (bus.rom_en)
            bus.rom_data <= rom_word(bus.rom_addr);
    end

    int tests = 0;
    int fails = 0;

    // Run configuration (-1 disables an option).
    int        cfg_full_from, cfg_full_n, cfg_abort_at, cfg_busy_start_at;
    int        cfg_rst_at, cfg_probe_at;
    logic [6:0] cfg_base;
    logic [7:0] cfg_len;

    // Per-run observations.
    int          rom_en_cnt, wr_cnt, wr_full_cnt, done_cnt, done_cyc, busy_cnt;
    int          first_rom_cyc, first_wr_cyc, last_rom_cyc;
    logic [31:0] wr_q[$];
    logic [6:0]  addr_q[$];
    int          wr_cyc_q[$];
    logic [42:0] probe_val;

    function automatic logic [42:0] outputs_now();
        return {bus.busy, bus.done, bus.rom_en, bus.rom_addr, bus.fifo_wr_en, bus.fifo_din};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_defaults(input logic [6:0] base, input logic [7:0] len);
        cfg_base = base; cfg_len = len;
        cfg_full_from = -1; cfg_full_n = 0; cfg_abort_at = -1;
        cfg_busy_start_at = -1; cfg_rst_at = -1; cfg_probe_at = -1;
    endtask

    // Entered just after a rising edge; each iteration is one clock cycle.
    task automatic run_cycles(input int n);
        rom_en_cnt = 0; wr_cnt = 0; wr_full_cnt = 0; done_cnt = 0; busy_cnt = 0;
        done_cyc = -1; first_rom_cyc = -1; first_wr_cyc = -1; last_rom_cyc = -1;
        wr_q.delete(); addr_q.delete(); wr_cyc_q.delete(); probe_val = '1;
        for (int c = 0; c < n; c++) begin
            bus.start     = (c == 0) || (c == cfg_abort_at) || (c == cfg_busy_start_at);
            bus.base_addr = (c == 0) ? cfg_base : 7'd50;
            bus.burst_len = (c == 0) ? cfg_len : 8'd8;
            bus.abort     = (c == cfg_abort_at);
            bus.fifo_full = (cfg_full_from >= 0) && (c >= cfg_full_from) &&
                            (c < cfg_full_from + cfg_full_n);
            rst_n         = (c != cfg_rst_at);
            #1;
            if (bus.rom_en) begin
                rom_en_cnt++;
                addr_q.push_back(bus.rom_addr);
                if (first_rom_cyc < 0) first_rom_cyc = c;
                last_rom_cyc = c;
            end
            if (bus.fifo_wr_en) begin
                wr_cnt++;
                if (bus.fifo_full) wr_full_cnt++;
                wr_q.push_back(bus.fifo_din);
                wr_cyc_q.push_back(c);
                if (first_wr_cyc < 0) first_wr_cyc = c;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.busy) busy_cnt++;
            if (c == cfg_probe_at) probe_val = outputs_now();
            @(posedge clk_in);
            #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.fifo_full = 1'b0; rst_n = 1'b1;
    endtask

    // Number of written words that differ from ROM[base], ROM[base+1], ... (mod 128).
    function automatic int data_errs(input logic [6:0] base);
        int e = 0;
        logic [6:0] a;
        for (int i = 0; i < wr_q.size(); i++) begin
            a = base + 7'(i);
            if (wr_q[i] !== rom_word(a)) e++;
        end
        return e;
    endfunction

    function automatic int addr_errs(input logic [6:0] base);
        int e = 0;
        logic [6:0] a;
        for (int i = 0; i < addr_q.size(); i++) begin
            a = base + 7'(i);
            if (addr_q[i] !== a) e++;
        end
        return e;
    endfunction

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.burst_len = '0;
        bus.abort = 1'b0; bus.fifo_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", 64'(outputs_now()), 64'd0);
        rst_n = 1'b1;

        // Full-length burst from address 0.
        set_defaults(7'd0, 8'd128);
        run_cycles(140);
        check("b128_rom_en_cnt", rom_en_cnt, 128);
        check("b128_wr_cnt", wr_cnt, 128);
        check("b128_data_errs", data_errs(7'd0), 0);
        check("b128_first_rom_en", first_rom_cyc, 1);
        check("b128_first_wr", first_wr_cyc, 2);
        check("b128_last_rom_en", last_rom_cyc, 128);
        check("b128_done_cnt", done_cnt, 1);
        check("b128_done_cyc", done_cyc, 131);
        check("b128_busy_cycles", busy_cnt, 131);

        // Address wrap inside a burst.
        set_defaults(7'd120, 8'd16);
        run_cycles(25);
        check("wrap_wr_cnt", wr_cnt, 16);
        check("wrap_addr_errs", addr_errs(7'd120), 0);
        check("wrap_data_errs", data_errs(7'd120), 0);
        check("wrap_addr9", (addr_q.size() > 8) ? 64'(addr_q[8]) : 64'hFF, 64'd0);
        check("wrap_done_cyc", done_cyc, 19);
        check("wrap_busy_cycles", busy_cnt, 19);

        // FIFO full for cycles 3..5 while the second word is in flight.
        set_defaults(7'd10, 8'd5);
        cfg_full_from = 3; cfg_full_n = 3;
        run_cycles(18);
        check("full_rom_en_cnt", rom_en_cnt, 5);
        check("full_wr_cnt", wr_cnt, 5);
        check("full_data_errs", data_errs(7'd10), 0);
        check("full_wr_while_full", wr_full_cnt, 0);
        check("full_skid_wr_cyc", (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : -1, 6);
        check("full_resume_wr_cyc", (wr_cyc_q.size() > 2) ? wr_cyc_q[2] : -1, 8);
        check("full_done_cyc", done_cyc, 12);
        check("full_busy_cycles", busy_cnt, 12);

        // Zero-length burst.
        set_defaults(7'd33, 8'd0);
        run_cycles(6);
        check("len0_rom_en_cnt", rom_en_cnt, 0);
        check("len0_wr_cnt", wr_cnt, 0);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_done_cyc", done_cyc, 1);
        check("len0_busy_cycles", busy_cnt, 1);

        // Abort with a simultaneous start, after the 10th read (cycle 11).
        set_defaults(7'd0, 8'd64);
        cfg_abort_at = 11; cfg_probe_at = 12;
        run_cycles(20);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_wr_cnt", wr_cnt, 10);
        check("abort_data_errs", data_errs(7'd0), 0);
        check("abort_busy_cycles", busy_cnt, 11);
        check("abort_busy_next", 64'(probe_val[42]), 64'd0);

        // Fresh burst after the abort.
        set_defaults(7'd5, 8'd3);
        run_cycles(10);
        check("post_abort_wr_cnt", wr_cnt, 3);
        check("post_abort_data_errs", data_errs(7'd5), 0);
        check("post_abort_done_cyc", done_cyc, 6);

        // Start while busy (cycle 4), then reset pulse in cycle 8.
        set_defaults(7'd0, 8'd20);
        cfg_busy_start_at = 4; cfg_rst_at = 8; cfg_probe_at = 9;
        run_cycles(14);
        check("rst_outputs_next", 64'(probe_val), 64'd0);
        check("rst_addr_errs", addr_errs(7'd0), 0);
        check("rst_wr_cnt", wr_cnt, 7);
        check("rst_data_errs", data_errs(7'd0), 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_busy_cycles", busy_cnt, 8);

        // Restart after reset.
        set_defaults(7'd3, 8'd4);
        run_cycles(10);
        check("restart_wr_cnt", wr_cnt, 4);
        check("restart_data_errs", data_errs(7'd3), 0);
        check("restart_done_cyc", done_cyc, 7);

        // Oversized length clamps to 128 words.
        set_defaults(7'd100, 8'd200);
        run_cycles(140);
        check("sat_wr_cnt", wr_cnt, 128);
        check("sat_data_errs", data_errs(7'd100), 0);
        check("sat_busy_cycles", busy_cnt, 131);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
